// File: rtl/adc_sample_averager.sv
// Per-channel power-of-two boxcar averager for ADC128S022 results, with a ready/valid
// output and a bank of last averages. Define ADC_AVG_ROUND_EN for round-half-up with saturation.
module adc_sample_averager #(
    parameter int AVG_LOG2 = 3,
    parameter int DATA_W   = 12,
    parameter int NUM_CH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [2:0]        sample_chan,
    input  logic              sample_valid,
    input  logic              flush,
    output logic [DATA_W-1:0] avg_data,
    output logic [2:0]        avg_chan,
    output logic              avg_valid,
    input  logic              avg_ready,
    input  logic [2:0]        rd_chan,
    output logic [DATA_W-1:0] rd_data,
    output logic [AVG_LOG2:0] fill_cnt,
    output logic              overrun
);

`ifdef ADC_AVG_ROUND_EN
    localparam int ACC_W = DATA_W + AVG_LOG2 + 1;
`else
    localparam int ACC_W = DATA_W + AVG_LOG2;
`endif
    localparam int               CNT_W    = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_t;

    logic [ACC_W-1:0]  acc_vec  [NUM_CH];
    logic [CNT_W-1:0]  cnt_vec  [NUM_CH];
    logic [DATA_W-1:0] bank_vec [NUM_CH];

    logic [ACC_W-1:0]  sel_acc;
    logic [CNT_W-1:0]  sel_cnt;
    logic [ACC_W-1:0]  acc_add;
    logic [DATA_W-1:0] avg_value;
    logic              take;
    logic              complete;

    out_state_t        state_q, state_d;
    logic              load_out;
    logic              set_overrun;
    logic [DATA_W-1:0] avg_data_q;
    logic [2:0]        avg_chan_q;
    logic              overrun_q;

    // A sample coinciding with flush is discarded outright.
    assign take     = sample_valid && !flush;
    assign sel_acc  = acc_vec[sample_chan];
    assign sel_cnt  = cnt_vec[sample_chan];
    assign acc_add  = sel_acc + ACC_W'(sample_data);
    assign complete = take && (sel_cnt == CNT_LAST);

`ifdef ADC_AVG_ROUND_EN
    localparam int               RND_SH = (AVG_LOG2 > 0) ? AVG_LOG2 - 1 : 0;
    localparam logic [ACC_W-1:0] RND    = (AVG_LOG2 > 0) ? (ACC_W'(1) << RND_SH) : '0;

    logic [ACC_W-1:0] sum_rnd;
    logic [ACC_W-1:0] shifted;

    assign sum_rnd   = acc_add + RND;
    assign shifted   = sum_rnd >> AVG_LOG2;
    assign avg_value = (|shifted[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
`else
    assign avg_value = DATA_W'(acc_add >> AVG_LOG2);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ACC_W-1:0]  acc_q;
            logic [CNT_W-1:0]  cnt_q;
            logic [DATA_W-1:0] bank_q;
            logic              hit;

            assign hit = take && (sample_chan == 3'(gi));

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end else if (hit) begin
                    if (cnt_q == CNT_LAST) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        acc_q <= acc_add;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end

            // The bank survives flush so the display keeps the last good value.
            always_ff @(posedge clk) begin
                if (rst) begin
                    bank_q <= '0;
                end else if (hit && (cnt_q == CNT_LAST)) begin
                    bank_q <= avg_value;
                end
            end

            assign acc_vec[gi]  = acc_q;
            assign cnt_vec[gi]  = cnt_q;
            assign bank_vec[gi] = bank_q;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        set_overrun = 1'b0;
        unique case (state_q)
            OUT_EMPTY: begin
                if (complete) begin
                    load_out = 1'b1;
                    state_d  = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (avg_ready) begin
                    if (complete) begin
                        load_out = 1'b1;
                    end else begin
                        state_d = OUT_EMPTY;
                    end
                end else if (complete) begin
                    set_overrun = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q    <= OUT_EMPTY;
            avg_data_q <= '0;
            avg_chan_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                avg_data_q <= avg_value;
                avg_chan_q <= sample_chan;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (set_overrun) begin
            overrun_q <= 1'b1;
        end
    end

    assign avg_data  = avg_data_q;
    assign avg_chan  = avg_chan_q;
    assign avg_valid = (state_q == OUT_FULL);
    assign overrun   = overrun_q;
    assign rd_data   = bank_vec[rd_chan];
    assign fill_cnt  = cnt_vec[sample_chan];

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench for adc_sample_averager: directed scenarios plus random traffic
// against a sample-list reference model; a second instance covers the AVG_LOG2=0 build.
`timescale 1ns/1ps
module tb_adc_sample_averager;
    localparam int DATA_W   = 12;
    localparam int NCH      = 8;
    localparam int AVG_LOG2 = 3;
    localparam int N        = 1 << AVG_LOG2;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic              rst, sample_valid, flush, avg_ready, avg_valid, overrun;
    logic [DATA_W-1:0] sample_data, avg_data, rd_data;
    logic [2:0]        sample_chan, avg_chan, rd_chan;
    logic [AVG_LOG2:0] fill_cnt;

    logic              avg_ready0, avg_valid0, overrun0;
    logic [DATA_W-1:0] avg_data0, rd_data0;
    logic [2:0]        avg_chan0;
    logic [0:0]        fill_cnt0;

    adc_sample_averager #(.AVG_LOG2(AVG_LOG2), .DATA_W(DATA_W), .NUM_CH(NCH)) dut (
        .clk(clk), .rst(rst), .sample_data(sample_data), .sample_chan(sample_chan),
        .sample_valid(sample_valid), .flush(flush), .avg_data(avg_data), .avg_chan(avg_chan),
        .avg_valid(avg_valid), .avg_ready(avg_ready), .rd_chan(rd_chan), .rd_data(rd_data),
        .fill_cnt(fill_cnt), .overrun(overrun)
    );

    adc_sample_averager #(.AVG_LOG2(0), .DATA_W(DATA_W), .NUM_CH(NCH)) dut0 (
        .clk(clk), .rst(rst), .sample_data(sample_data), .sample_chan(sample_chan),
        .sample_valid(sample_valid), .flush(flush), .avg_data(avg_data0), .avg_chan(avg_chan0),
        .avg_valid(avg_valid0), .avg_ready(avg_ready0), .rd_chan(rd_chan), .rd_data(rd_data0),
        .fill_cnt(fill_cnt0), .overrun(overrun0)
    );

    // Reference model: raw sample lists per channel, averaged by plain arithmetic.
    int samp [NCH][$];
    int m_bank [NCH];
    int bank0 [NCH];
    bit m_valid, m_overrun;
    int m_data, m_chan;

    int cmp_cnt = 0;
    int err_cnt = 0;

    function automatic int avg_of(input int sum, input int n);
        int r;
`ifdef ADC_AVG_ROUND_EN
        r = (sum + n / 2) / n;
        if (r > (1 << DATA_W) - 1) r = (1 << DATA_W) - 1;
`else
        r = sum / n;
`endif
        return r;
    endfunction

    task automatic model_edge();
        int ch, sum, a;
        bit done;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                samp[c].delete();
                m_bank[c] = 0;
                bank0[c]  = 0;
            end
            m_valid = 0; m_data = 0; m_chan = 0; m_overrun = 0;
            return;
        end
        if (flush) begin
            for (int c = 0; c < NCH; c++) samp[c].delete();
            m_valid = 0; m_data = 0; m_chan = 0;
            return;
        end
        done = 0; a = 0;
        ch = int'(sample_chan);
        if (sample_valid) begin
            bank0[ch] = avg_of(int'(sample_data), 1);
            samp[ch].push_back(int'(sample_data));
            if (samp[ch].size() == N) begin
                sum = 0;
                for (int k = 0; k < samp[ch].size(); k++) sum += samp[ch][k];
                a = avg_of(sum, N);
                m_bank[ch] = a;
                samp[ch].delete();
                done = 1;
            end
        end
        if (m_valid && !avg_ready) begin
            if (done) m_overrun = 1;
        end else if (done) begin
            m_valid = 1; m_data = a; m_chan = ch;
        end else if (m_valid) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input bit v, input int ch, input int d, input bit fl, input bit rdy);
        sample_valid = v;
        sample_chan  = 3'(ch);
        sample_data  = 12'(d);
        flush        = fl;
        avg_ready    = rdy;
        model_edge();
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 1);
        rst = 1'b0;
        cmp_cnt++;
        if (avg_valid !== 1'b0 || overrun !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_flags: got valid=%0b overrun=%0b expected 0/0", avg_valid, overrun);
        end
        cmp_cnt++;
        if (avg_data !== 12'd0 || avg_chan !== 3'd0) begin
            err_cnt++;
            $display("FAIL reset_data: got data=%0d chan=%0d expected 0/0", avg_data, avg_chan);
        end
        for (int c = 0; c < NCH; c++) begin
            rd_chan = 3'(c); sample_chan = 3'(c);
            #1;
            cmp_cnt++;
            if (rd_data !== 12'd0 || fill_cnt !== '0) begin
                err_cnt++;
                $display("FAIL reset_bank ch%0d: got bank=%0d fill=%0d expected 0/0", c, rd_data, fill_cnt);
            end
        end
    endtask

    task automatic test_truncation();
        int exp_avg;
`ifdef ADC_AVG_ROUND_EN
        exp_avg = 104;
`else
        exp_avg = 103;
`endif
        for (int i = 0; i < N; i++) begin
            step(1, 2, 100 + i, 0, 1);
            cmp_cnt++;
            if (avg_valid !== m_valid) begin
                err_cnt++;
                $display("FAIL trunc_valid step%0d: got %0b expected %0b", i, avg_valid, m_valid);
            end
        end
        cmp_cnt++;
        if (avg_valid !== 1'b1 || avg_data !== 12'(exp_avg) || avg_chan !== 3'd2) begin
            err_cnt++;
            $display("FAIL trunc_result: got v=%0b d=%0d ch=%0d expected 1/%0d/2", avg_valid, avg_data, avg_chan, exp_avg);
        end
        $display("txn trunc ch=%0d avg=%0d", avg_chan, avg_data);
        step(0, 2, 0, 0, 1);
        rd_chan = 3'd2;
        #1;
        cmp_cnt++;
        if (avg_valid !== 1'b0 || rd_data !== 12'(exp_avg) || fill_cnt !== '0) begin
            err_cnt++;
            $display("FAIL trunc_after: got v=%0b bank=%0d fill=%0d expected 0/%0d/0", avg_valid, rd_data, fill_cnt, exp_avg);
        end
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 2 * N; i++) begin
            step(1, (i % 2 == 0) ? 0 : 5, (i % 2 == 0) ? 4095 : 0, 0, 1);
            cmp_cnt++;
            if (avg_valid !== m_valid || avg_data !== 12'(m_data) || avg_chan !== 3'(m_chan)) begin
                err_cnt++;
                $display("FAIL inter_out step%0d: got v=%0b d=%0d ch=%0d expected %0b/%0d/%0d",
                         i, avg_valid, avg_data, avg_chan, m_valid, m_data, m_chan);
            end
            if (avg_valid) $display("txn inter ch=%0d avg=%0d", avg_chan, avg_data);
        end
        rd_chan = 3'd0;
        #1;
        cmp_cnt++;
        if (rd_data !== 12'd4095) begin
            err_cnt++;
            $display("FAIL inter_bank0: got %0d expected 4095", rd_data);
        end
        rd_chan = 3'd5;
        #1;
        cmp_cnt++;
        if (rd_data !== 12'd0) begin
            err_cnt++;
            $display("FAIL inter_bank5: got %0d expected 0", rd_data);
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 2 * N; i++) begin
            step(1, (i < N) ? 1 : 3, (i < N) ? 200 : 300, 0, 0);
            cmp_cnt++;
            if (avg_valid !== m_valid || avg_data !== 12'(m_data) || overrun !== m_overrun) begin
                err_cnt++;
                $display("FAIL bp_step%0d: got v=%0b d=%0d ov=%0b expected %0b/%0d/%0b",
                         i, avg_valid, avg_data, overrun, m_valid, m_data, m_overrun);
            end
        end
        rd_chan = 3'd3;
        #1;
        cmp_cnt++;
        if (avg_data !== 12'd200 || avg_chan !== 3'd1 || overrun !== 1'b1 || rd_data !== 12'd300) begin
            err_cnt++;
            $display("FAIL bp_hold: got d=%0d ch=%0d ov=%0b bank3=%0d expected 200/1/1/300",
                     avg_data, avg_chan, overrun, rd_data);
        end
        step(0, 0, 0, 0, 1);
        cmp_cnt++;
        if (avg_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_release: got valid=%0b expected 0", avg_valid);
        end
        $display("txn bp ch=%0d avg=%0d accepted", avg_chan, avg_data);
    endtask

    task automatic test_flush();
        for (int i = 0; i < N; i++) step(1, 4, 777, 0, 1);
        step(0, 4, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 4, 1000, 0, 1);
        #1;
        cmp_cnt++;
        if (fill_cnt !== 4'd5) begin
            err_cnt++;
            $display("FAIL flush_partial: got fill=%0d expected 5", fill_cnt);
        end
        step(1, 4, 1000, 1, 1);
        rd_chan = 3'd4;
        #1;
        cmp_cnt++;
        if (fill_cnt !== '0 || rd_data !== 12'd777 || avg_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_clear: got fill=%0d bank=%0d v=%0b expected 0/777/0", fill_cnt, rd_data, avg_valid);
        end
        for (int i = 0; i < N; i++) step(1, 4, 40, 0, 1);
        #1;
        cmp_cnt++;
        if (avg_valid !== 1'b1 || avg_data !== 12'd40 || avg_chan !== 3'd4 || rd_data !== 12'd40) begin
            err_cnt++;
            $display("FAIL flush_result: got v=%0b d=%0d ch=%0d bank=%0d expected 1/40/4/40",
                     avg_valid, avg_data, avg_chan, rd_data);
        end
        cmp_cnt++;
        if (overrun !== m_overrun) begin
            err_cnt++;
            $display("FAIL flush_overrun: got %0b expected %0b", overrun, m_overrun);
        end
        $display("txn flush ch=%0d avg=%0d", avg_chan, avg_data);
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) step(1, 6, $urandom_range(0, 4095), 0, 0);
        for (int i = 0; i < 3; i++) step(1, 7, $urandom_range(0, 4095), 0, 0);
        cmp_cnt++;
        if (avg_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL rstmid_pre: got valid=%0b expected 1", avg_valid);
        end
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        cmp_cnt++;
        if (avg_valid !== 1'b0 || avg_data !== 12'd0 || avg_chan !== 3'd0 || overrun !== 1'b0) begin
            err_cnt++;
            $display("FAIL rstmid_out: got v=%0b d=%0d ch=%0d ov=%0b expected all 0",
                     avg_valid, avg_data, avg_chan, overrun);
        end
        for (int c = 0; c < NCH; c++) begin
            sample_chan = 3'(c); rd_chan = 3'(c);
            #1;
            cmp_cnt++;
            if (fill_cnt !== '0 || rd_data !== 12'd0) begin
                err_cnt++;
                $display("FAIL rstmid_ch%0d: got fill=%0d bank=%0d expected 0/0", c, fill_cnt, rd_data);
            end
        end
    endtask

    task automatic test_random();
        bit v, fl, rdy, prev0, was_valid;
        int ch, d, rc;
        was_valid = 0;
        for (int i = 0; i < 500; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            ch  = $urandom_range(0, NCH - 1);
            d   = $urandom_range(0, 4095);
            fl  = ($urandom_range(0, 31) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            prev0 = v && !fl;
            step(v, ch, d, fl, rdy);
            cmp_cnt++;
            if (avg_valid !== m_valid || avg_data !== 12'(m_data) || avg_chan !== 3'(m_chan)
                || overrun !== m_overrun) begin
                err_cnt++;
                $display("FAIL rand_out cyc%0d: got v=%0b d=%0d ch=%0d ov=%0b expected %0b/%0d/%0d/%0b",
                         i, avg_valid, avg_data, avg_chan, overrun, m_valid, m_data, m_chan, m_overrun);
            end
            if (avg_valid && !was_valid) $display("txn rand ch=%0d avg=%0d", avg_chan, avg_data);
            was_valid = avg_valid;
            rc = $urandom_range(0, NCH - 1);
            rd_chan = 3'(rc);
            #1;
            cmp_cnt++;
            if (rd_data !== 12'(m_bank[rc]) || rd_data0 !== 12'(bank0[rc])) begin
                err_cnt++;
                $display("FAIL rand_bank ch%0d: got %0d/%0d expected %0d/%0d", rc, rd_data, rd_data0, m_bank[rc], bank0[rc]);
            end
            cmp_cnt++;
            if (avg_valid0 !== prev0 || overrun0 !== 1'b0 || fill_cnt0 !== 1'b0) begin
                err_cnt++;
                $display("FAIL pass_flags cyc%0d: got v=%0b ov=%0b fill=%0d expected %0b/0/0",
                         i, avg_valid0, overrun0, fill_cnt0, prev0);
            end
            if (prev0) begin
                cmp_cnt++;
                if (avg_data0 !== 12'(d) || avg_chan0 !== 3'(ch)) begin
                    err_cnt++;
                    $display("FAIL pass_data cyc%0d: got d=%0d ch=%0d expected %0d/%0d", i, avg_data0, avg_chan0, d, ch);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; sample_valid = 1'b0; flush = 1'b0; avg_ready = 1'b1; avg_ready0 = 1'b1;
        sample_data = '0; sample_chan = '0; rd_chan = '0;
        test_reset();
        test_truncation();
        test_interleave();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
